// File: rtl/eth_ctrl_pkg.sv
// Shared definitions for the Ethernet reset sequencer and MAC control-command queue.
package eth_ctrl_pkg;

  localparam int CMD_WIDTH_DEF = 4;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_RELEASE   = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_SOFT      = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eth_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module eth_cmd_fifo import eth_ctrl_pkg::*; #(
  parameter int WIDTH = CMD_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign level     = wr_ptr_r - rd_ptr_r;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is only consumed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push_s && !rst) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/eth_ctrl_sequencer.sv
// Staged reset release after filtered MMCM lock, plus a buffered valid/ready command path to the MAC.
module eth_ctrl_sequencer import eth_ctrl_pkg::*; #(
  parameter int NUM_DOMAINS     = 3,
  parameter int LOCK_FILTER     = 8,
  parameter int STAGE_CYCLES    = 16,
  parameter int SOFT_RST_CYCLES = 32,
  parameter int CMD_WIDTH       = CMD_WIDTH_DEF,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          axi_lite_clk,
  input  logic                          sys_rst,
  input  logic                          mmcm_locked,
  input  logic                          soft_rst_req,
  output logic [NUM_DOMAINS-1:0]        rst_out,
  output logic                          seq_done,
  output logic                          start_config,
  input  logic [CMD_WIDTH-1:0]          cmd_in_data,
  input  logic                          cmd_in_valid,
  output logic                          cmd_in_ready,
  output logic [CMD_WIDTH-1:0]          control_data,
  output logic                          control_valid,
  input  logic                          control_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(max3(LOCK_FILTER, STAGE_CYCLES, SOFT_RST_CYCLES) + 1);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic [1:0]             state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       idx_r;
  logic [NUM_DOMAINS-1:0] rst_out_r;
  logic                   seq_done_r;
  logic                   start_config_r;
  logic                   ctrl_valid_r;
  logic [CMD_WIDTH-1:0]   ctrl_data_r;

  logic                   lock_lost_s;
  logic                   soft_go_s;
  logic                   flush_s;
  logic                   push_s;
  logic                   load_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CMD_WIDTH-1:0]   fifo_head_s;

  // Lock loss outranks a soft-reset request; both discard queued commands.
  assign lock_lost_s  = !mmcm_locked && (state_r != ST_WAIT_LOCK);
  assign soft_go_s    = soft_rst_req && mmcm_locked && ((state_r == ST_RELEASE) || (state_r == ST_RUN));
  assign flush_s      = lock_lost_s || soft_go_s;
  assign cmd_in_ready = !fifo_full_s && !sys_rst;
  assign push_s       = cmd_in_valid && cmd_in_ready;
  assign load_s       = (state_r == ST_RUN) && !fifo_empty_s && (!ctrl_valid_r || control_ready) && !flush_s;

  assign rst_out       = rst_out_r;
  assign seq_done      = seq_done_r;
  assign start_config  = start_config_r;
  assign control_valid = ctrl_valid_r;
  assign control_data  = ctrl_data_r;

  eth_cmd_fifo #(.WIDTH(CMD_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (axi_lite_clk),
    .rst   (sys_rst),
    .flush (flush_s),
    .push  (push_s),
    .pop   (load_s),
    .din   (cmd_in_data),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // Sequencer FSM: cnt_r is the lock filter, stage timer or soft-hold timer depending on state.
  always_ff @(posedge axi_lite_clk) begin
    if (sys_rst || flush_s) begin
      state_r        <= soft_go_s && !sys_rst ? ST_SOFT : ST_WAIT_LOCK;
      cnt_r          <= {CNT_W{1'b0}};
      idx_r          <= {IDX_W{1'b0}};
      rst_out_r      <= {NUM_DOMAINS{1'b1}};
      seq_done_r     <= 1'b0;
      start_config_r <= 1'b0;
    end else begin
      start_config_r <= 1'b0;
      case (state_r)
        ST_WAIT_LOCK: begin
          if (!mmcm_locked) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (cnt_r == CNT_W'(LOCK_FILTER - 1)) begin
            state_r <= ST_RELEASE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_r == CNT_W'(STAGE_CYCLES - 1)) begin
            rst_out_r[idx_r] <= 1'b0;
            cnt_r            <= {CNT_W{1'b0}};
            if (idx_r == IDX_W'(NUM_DOMAINS - 1)) begin
              state_r        <= ST_RUN;
              seq_done_r     <= 1'b1;
              start_config_r <= 1'b1;
              idx_r          <= {IDX_W{1'b0}};
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          seq_done_r <= 1'b1;
        end
        ST_SOFT: begin
          if (cnt_r == CNT_W'(SOFT_RST_CYCLES - 1)) begin
            state_r <= ST_RELEASE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r   <= ST_WAIT_LOCK;
          cnt_r     <= {CNT_W{1'b0}};
          idx_r     <= {IDX_W{1'b0}};
          rst_out_r <= {NUM_DOMAINS{1'b1}};
        end
      endcase
    end
  end

  // Output register: data holds while the MAC stalls, refills from the FIFO head otherwise.
  always_ff @(posedge axi_lite_clk) begin
    if (sys_rst || flush_s) begin
      ctrl_valid_r <= 1'b0;
      ctrl_data_r  <= {CMD_WIDTH{1'b0}};
    end else if (load_s) begin
      ctrl_valid_r <= 1'b1;
      ctrl_data_r  <= fifo_head_s;
    end else if (control_ready) begin
      ctrl_valid_r <= 1'b0;
    end else begin
      ctrl_valid_r <= ctrl_valid_r;
    end
  end

endmodule
